serial_word_receiver: RTL and testbench

SERIAL_WORD_RECEIVER -- requirements
Module: serial_word_receiver

---
 rtl/serial_word_receiver_pkg.sv | 11 +
 rtl/serial_word_receiver_sipo_shift_core.sv | 32 +++
 rtl/serial_word_receiver.sv | 104 ++++++++++
 tb/tb_serial_word_receiver.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/serial_word_receiver_pkg.sv
// Shared types and constants for the serial word receiver.
package serial_word_receiver_pkg;

    localparam int unsigned DEFAULT_N = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/serial_word_receiver_sipo_shift_core.sv
// N-bit MSB-first serial-in parallel-out shift register.
// clr_i together with en_i starts a new word with bit_i as its first (MSB) bit.
module sipo_shift_core #(
    parameter int unsigned N = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         bit_i,
    output logic [N-1:0] data_o
);

    logic [N-1:0] data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (en_i) begin
            if (clr_i) begin
                data_q <= {{(N-1){1'b0}}, bit_i};
            end else begin
                data_q <= {data_q[N-2:0], bit_i};
            end
        end else if (clr_i) begin
            data_q <= '0;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/serial_word_receiver.sv
// Frames MSB-first serial bits into N-bit words and hands them off over a
// valid/ready interface; a word completing while one is still pending is dropped.
module serial_word_receiver
    import serial_word_receiver_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         serial_i,
    input  logic         bit_valid_i,
    input  logic         start_i,
    output logic [N-1:0] word_o,
    output logic         word_valid_o,
    input  logic         word_ready_i,
    output logic         busy_o,
    output logic         overrun_o,
    input  logic         clear_i
);

    localparam int unsigned   CW       = $clog2(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    state_e          state_q;
    logic [CW-1:0]   count_q;
    logic [N-1:0]    word_q;
    logic            word_valid_q;
    logic            busy_q;
    logic            overrun_q;

    logic [N-1:0]    shift_data;
    logic [N-1:0]    candidate;
    logic            take_start;
    logic            take_bit;
    logic            complete;
    logic            transfer;
    logic            drop_word;

    // A start bit always (re)opens a frame; plain bits only count inside one.
    assign take_start = bit_valid_i & start_i;
    assign take_bit   = bit_valid_i & ~start_i & (state_q == ST_SHIFT);
    assign complete   = take_bit & (count_q == LAST_CNT);
    assign transfer   = word_valid_q & word_ready_i;
    assign drop_word  = complete & word_valid_q & ~word_ready_i;
    assign candidate  = {shift_data[N-2:0], serial_i};

    sipo_shift_core #(
        .N(N)
    ) u_shift (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (take_start | take_bit),
        .clr_i  (take_start),
        .bit_i  (serial_i),
        .data_o (shift_data)
    );

    // Frame FSM and bit counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else if (take_start) begin
            state_q <= ST_SHIFT;
            count_q <= CW'(1);
            busy_q  <= 1'b1;
        end else if (complete) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else if (take_bit) begin
            count_q <= count_q + CW'(1);
        end
    end

    // Output word handshake and sticky overrun flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_q       <= '0;
            word_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (complete && (!word_valid_q || word_ready_i)) begin
                word_q       <= candidate;
                word_valid_q <= 1'b1;
            end else if (transfer) begin
                word_valid_q <= 1'b0;
            end

            if (drop_word) begin
                overrun_q <= 1'b1;
            end else if (clear_i) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = word_valid_q;
    assign busy_o       = busy_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed and loopback test of serial_word_receiver with N=8.
module tb_serial_word_receiver;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       serial_i = 1'b0;
    logic       bit_valid_i = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] word_o;
    logic       word_valid_o;
    logic       word_ready_i = 1'b0;
    logic       busy_o;
    logic       overrun_o;
    logic       clear_i = 1'b0;

    int checks = 0;
    int errors = 0;

    serial_word_receiver #(.N(8)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .serial_i     (serial_i),
        .bit_valid_i  (bit_valid_i),
        .start_i      (start_i),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .busy_o       (busy_o),
        .overrun_o    (overrun_o),
        .clear_i      (clear_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive nbits bits of w MSB first on consecutive edges; start on the first.
    task automatic send_bits(input logic [7:0] w, input int nbits, input bit rdy_last);
        for (int i = 0; i < nbits; i++) begin
            serial_i     = w[7-i];
            start_i      = (i == 0);
            bit_valid_i  = 1'b1;
            word_ready_i = rdy_last && (i == nbits - 1);
            @(negedge clk_i);
        end
        bit_valid_i  = 1'b0;
        start_i      = 1'b0;
        word_ready_i = 1'b0;
        serial_i     = 1'b0;
    endtask

    task automatic drain_one();
        word_ready_i = 1'b1;
        @(negedge clk_i);
        word_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (word_o !== 8'h00) begin errors++; $display("FAIL reset_word: got %h want 00", word_o); end
        checks++; if (word_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", word_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        // Bits without start are ignored in IDLE.
        serial_i = 1'b1; bit_valid_i = 1'b1;
        repeat (3) @(negedge clk_i);
        bit_valid_i = 1'b0; serial_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_ignore_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_basic();
        send_bits(8'hA5, 4, 1'b0);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_midframe_busy: got %b want 1", busy_o); end
        // Finish the frame with the remaining bits 0101 (no start).
        for (int i = 4; i < 8; i++) begin
            serial_i = (i == 5 || i == 7); bit_valid_i = 1'b1;
            @(negedge clk_i);
        end
        bit_valid_i = 1'b0; serial_i = 1'b0;
        checks++; if (word_o !== 8'hA5) begin errors++; $display("FAIL basic_word: got %h want a5", word_o); end
        checks++; if (word_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", word_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b want 0", busy_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b want 0", overrun_o); end
    endtask

    task automatic test_overrun();
        send_bits(8'h3C, 8, 1'b0);
        checks++; if (word_o !== 8'hA5) begin errors++; $display("FAIL overrun_word: got %h want a5", word_o); end
        checks++; if (word_valid_o !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b want 1", word_valid_o); end
        checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b want 1", overrun_o); end
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b want 0", overrun_o); end
        checks++; if (word_o !== 8'hA5) begin errors++; $display("FAIL overrun_word_hold: got %h want a5", word_o); end
    endtask

    task automatic test_same_edge_transfer();
        send_bits(8'h3C, 8, 1'b1);
        checks++; if (word_o !== 8'h3C) begin errors++; $display("FAIL same_edge_word: got %h want 3c", word_o); end
        checks++; if (word_valid_o !== 1'b1) begin errors++; $display("FAIL same_edge_valid: got %b want 1", word_valid_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL same_edge_overrun: got %b want 0", overrun_o); end
        drain_one();
        checks++; if (word_valid_o !== 1'b0) begin errors++; $display("FAIL same_edge_drain: got %b want 0", word_valid_o); end
    endtask

    task automatic test_restart();
        send_bits(8'h55, 5, 1'b0);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL restart_busy: got %b want 1", busy_o); end
        send_bits(8'hFF, 8, 1'b0);
        checks++; if (word_o !== 8'hFF) begin errors++; $display("FAIL restart_word: got %h want ff", word_o); end
        checks++; if (word_valid_o !== 1'b1) begin errors++; $display("FAIL restart_valid: got %b want 1", word_valid_o); end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL restart_overrun: got %b want 0", overrun_o); end
        drain_one();
        checks++; if (word_valid_o !== 1'b0) begin errors++; $display("FAIL restart_single_word: got %b want 0", word_valid_o); end
    endtask

    task automatic test_async_reset();
        send_bits(8'hA5, 8, 1'b0);
        send_bits(8'h81, 4, 1'b0);
        checks++; if (busy_o !== 1'b1 || word_valid_o !== 1'b1) begin errors++; $display("FAIL areset_pre: busy %b valid %b want 1 1", busy_o, word_valid_o); end
        #2;
        rst_i = 1'b1;
        #1;
        checks++; if ({word_o, word_valid_o, busy_o, overrun_o} !== 11'd0) begin
            errors++; $display("FAIL areset_outputs: word %h valid %b busy %b ovr %b want all 0", word_o, word_valid_o, busy_o, overrun_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        // Trailing bits of the killed frame must not complete anything.
        serial_i = 1'b1; bit_valid_i = 1'b1;
        repeat (4) @(negedge clk_i);
        bit_valid_i = 1'b0; serial_i = 1'b0;
        checks++; if (word_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL areset_no_start: valid %b busy %b want 0 0", word_valid_o, busy_o); end
        send_bits(8'h81, 8, 1'b0);
        checks++; if (word_o !== 8'h81) begin errors++; $display("FAIL areset_next_word: got %h want 81", word_o); end
        checks++; if (word_valid_o !== 1'b1) begin errors++; $display("FAIL areset_next_valid: got %b want 1", word_valid_o); end
        drain_one();
    endtask

    task automatic test_loopback();
        logic [7:0] w;
        logic [7:0] piso;
        for (int k = 0; k < 1000; k++) begin
            w    = 8'($urandom);
            piso = w;
            for (int i = 0; i < 8; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk_i);
                serial_i    = piso[7];
                start_i     = (i == 0);
                bit_valid_i = 1'b1;
                @(negedge clk_i);
                bit_valid_i = 1'b0;
                start_i     = 1'b0;
                piso        = {piso[6:0], 1'b0};
            end
            checks++; if (word_valid_o !== 1'b1 || word_o !== w) begin
                errors++; $display("FAIL loopback_word %0d: got %h valid %b want %h", k, word_o, word_valid_o, w);
            end
            drain_one();
            checks++; if (word_valid_o !== 1'b0) begin errors++; $display("FAIL loopback_drain %0d: got %b want 0", k, word_valid_o); end
        end
        checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL loopback_overrun: got %b want 0", overrun_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_same_edge_transfer();
        test_restart();
        test_async_reset();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
